dmem_resp: RTL
==============

# dmem_resp

Data-memory responder at the far end of the core's memory path. Accepts the load/store request the MEM stage issues (write enable, address, store data, 4-bit memory op), performs byte/halfword/word access on an internal word-organised RAM, and returns sign- or zero-extended load data with a one-cycle acknowledge after a programmable number of wait states. The `busy_o` and `ack_o` outputs let the MEM stage stall the pipeline while an access is outstanding.

## Interface
- `DEPTH_LOG2`, 10, log2 of RAM depth in 32-bit words (default 1024 words).
- `WAIT_CYCLES`, 1, wait states between request acceptance and response, 0..15.
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  reset, asynchronous, active-high.
- `req_i`  input  1  request valid.
- `we_i`  input  1  store when 1, load when 0. Must agree with `op_i`.
- `addr_i`  input  `ADDR_WIDTH`  byte address.
- `wdata_i`  input  `DATA_WIDTH`  store data, right-aligned: byte in [7:0], halfword in [15:0].
- `op_i`  input  4  memory op, from defines.v: `MEM_NOP`=0, `MEM_LB`=1, `MEM_LH`=2, `MEM_LW`=3, `MEM_LBU`=4, `MEM_LHU`=5, `MEM_SB`=6, `MEM_SH`=7, `MEM_SW`=8.
- `ack_o`  output  1  one-cycle response strobe.
- `rdata_o`  output  `DATA_WIDTH`  load result, valid only while `ack_o`=1, otherwise 0.
- `err_o`  output  1  misaligned-access flag, valid with `ack_o`.
- `busy_o`  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: when `req_i`=1, latch `we_i`, `addr_i`, `wdata_i` and `op_i`. Go to WAIT if `WAIT_CYCLES`>0, else to RESP. Load the wait counter with `WAIT_CYCLES`-1.
- WAIT: decrement the counter each cycle. When it reaches 0, go to RESP. `req_i` is ignored.
- RESP: `ack_o`=1 for exactly one cycle, then return to IDLE.
- A store commits to RAM on the clock edge that enters RESP.
- A load reads the RAM on that same edge, so `rdata_o` is registered and valid in the RESP cycle.
- Word index is `addr[DEPTH_LOG2+1:2]`. Upper address bits are ignored, so addresses wrap modulo RAM size.
- Byte lanes are little-endian:
  - SB writes only lane `addr[1:0]`.
  - SH writes lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - SW writes all four lanes.
- Loads:
  - LB/LH sign-extend the selected byte or halfword to 32 bits.
  - LBU/LHU zero-extend it.
  - LW returns the full word.
- `MEM_NOP` or an undefined op with `req_i`=1: the request still completes. Response is `ack_o`=1, `rdata_o`=0, `err_o`=0, no RAM write.
- Stores return `rdata_o`=0.

## Timing
- Reset values: state IDLE, `ack_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0, counter 0. RAM contents are not reset.
- Latency: `ack_o` is asserted `WAIT_CYCLES`+1 cycles after the edge that accepts the request.
- Minimum spacing between accepted requests is `WAIT_CYCLES`+2 cycles.
- Handshake: the requester holds `req_i` and its payload until it sees `ack_o`, and drops `req_i` in the ack cycle. If `req_i` is still high in IDLE after RESP, it is treated as a new request.
- Reset asserted mid-access:
  - Returns to IDLE immediately; no ack is produced.
  - A store whose commit edge has not yet occurred is discarded.
- Reset and request on the same cycle: reset wins.

## Configuration
- `DMEM_MISALIGN_CHK_EN` defined: the access is misaligned when LH/LHU/SH has `addr[0]`=1, or LW/SW has `addr[1:0]`≠0. A misaligned access still completes with the normal latency, and:
  - `err_o`=1 together with `ack_o`;
  - `rdata_o`=0;
  - no RAM write.
- Undefined: `err_o` is tied to 0. Misaligned addresses are aligned down: `addr[0]` is ignored for halfword ops, `addr[1:0]` for word ops.

## Test plan
- SW 0xDEADBEEF to 0x10, then LW 0x10, with `WAIT_CYCLES`=1. Each `ack_o` rises 2 cycles after acceptance, and the load returns 0xDEADBEEF.
- SB 0x80 to 0x13, then LB 0x13 and LBU 0x13. Results are 0xFFFFFF80 and 0x00000080; LW 0x10 returns 0x80ADBEEF.
- SH 0x8001 to 0x12, then LH 0x12 and LHU 0x12. Results are 0xFFFF8001 and 0x00008001.
- SW 0x11111111 to 0x0, with reset asserted during WAIT. No `ack_o`; after reset, LW 0x0 returns the pre-store contents.
- LW 0x11 with `DMEM_MISALIGN_CHK_EN`: `ack_o`=1, `err_o`=1, `rdata_o`=0. Without the macro, the same load returns the word at 0x10 with `err_o`=0.
- `MEM_NOP` request with `WAIT_CYCLES`=0: `busy_o` is high for one cycle, `ack_o` follows 1 cycle after acceptance, `rdata_o`=0, and the RAM is unchanged.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: byte/halfword/word loads and stores on a word RAM, one-cycle ack after WAIT_CYCLES wait states.
// Optional misaligned-access detection is enabled by defining DMEM_MISALIGN_CHK_EN.
module dmem_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [3:0]            op_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int AW = DEPTH_LOG2 + 2;

    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LH  = 4'd2;
    localparam logic [3:0] MEM_LW  = 4'd3;
    localparam logic [3:0] MEM_LBU = 4'd4;
    localparam logic [3:0] MEM_LHU = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    function automatic logic is_store(input logic we, input logic [3:0] op);
        return we && (op inside {MEM_SB, MEM_SH, MEM_SW});
    endfunction

    function automatic logic is_load(input logic we, input logic [3:0] op);
        return !we && (op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU});
    endfunction

`ifdef DMEM_MISALIGN_CHK_EN
    function automatic logic misaligned(input logic [3:0] op, input logic [1:0] a);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return a[0];
            MEM_LW, MEM_SW:          return a != 2'b00;
            default:                 return 1'b0;
        endcase
    endfunction
`endif

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            op_q, op_d;

    logic                  enter_resp;
    logic                  mis_d, mis_q;
    logic                  ram_we;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wword;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_WIDTH-1:0] ram_word_q;
    logic [DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    logic unused_addr;
    assign unused_addr = ^addr_i[ADDR_WIDTH-1:AW];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i[AW-1:0];
                    wdata_d = wdata_i;
                    op_d    = op_i;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The RAM access uses the _d payload so a zero-wait request is served on its accept edge.
    assign enter_resp = !rst_i && (state_d == S_RESP) && (state_q != S_RESP);
    assign idx        = addr_d[AW-1:2];

`ifdef DMEM_MISALIGN_CHK_EN
    assign mis_d = misaligned(op_d, addr_d[1:0]);
    assign mis_q = misaligned(op_q, addr_q[1:0]);
`else
    assign mis_d = 1'b0;
    assign mis_q = 1'b0;
`endif

    always_comb begin
        be    = 4'b1111;
        wword = wdata_d;
        case (op_d)
            MEM_SB: begin
                be    = 4'b0001 << addr_d[1:0];
                wword = {4{wdata_d[7:0]}};
            end
            MEM_SH: begin
                be    = addr_d[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata_d[15:0]}};
            end
            default: ;
        endcase
        ram_we = enter_resp && is_store(we_d, op_d) && !mis_d;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
        end
    end

    // NOTE: the RAM array has no reset; a reset term would prevent block-RAM mapping.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
        end
        if (enter_resp) ram_word_q <= mem[idx];
    end

    always_comb begin
        logic [7:0]  lb;
        logic [15:0] lh;
        lb = ram_word_q[8*addr_q[1:0] +: 8];
        lh = addr_q[1] ? ram_word_q[31:16] : ram_word_q[15:0];
        rdata_o = '0;
        if (state_q == S_RESP && is_load(we_q, op_q) && !mis_q) begin
            case (op_q)
                MEM_LB:  rdata_o = {{24{lb[7]}}, lb};
                MEM_LBU: rdata_o = {24'd0, lb};
                MEM_LH:  rdata_o = {{16{lh[15]}}, lh};
                MEM_LHU: rdata_o = {16'd0, lh};
                default: rdata_o = ram_word_q;
            endcase
        end
    end

    assign ack_o  = (state_q == S_RESP);
    assign err_o  = ack_o && mis_q;
    assign busy_o = (state_q != S_IDLE);

endmodule
